// File: rtl/score_display_if.sv
// score_display_if: display-side bundle between the scoreboard counter and
// the two-digit 7-segment display driver.
//   master: the counter / test driver (drives value_i, observes the display)
//   slave : score_display (samples value_i, drives the display outputs)
interface score_display_if #(
  parameter int BW = 7
);
  logic [BW-1:0] value_i;
  logic [6:0]    segments_o;
  logic [1:0]    digit_sel_o;
  logic [3:0]    tens_o;
  logic [3:0]    ones_o;
  logic          done_o;

  modport master (
    output value_i,
    input  segments_o,
    input  digit_sel_o,
    input  tens_o,
    input  ones_o,
    input  done_o
  );

  modport slave (
    input  value_i,
    output segments_o,
    output digit_sel_o,
    output tens_o,
    output ones_o,
    output done_o
  );
endinterface

// File: rtl/score_display.sv
// score_display: converts the 0..99 score to two BCD digits with a
// sequential double-dabble engine (IDLE -> SHIFT x BW -> UPDATE, running
// continuously) and time-multiplexes them onto one shared 7-segment bus.
// Optional build macro SCORE_BLANK_LEADING_ZERO_EN blanks the tens digit
// when it is zero; the BCD outputs and done pulse are the same in both builds.
module score_display #(
  parameter int BW          = 7,
  parameter int REFRESH_DIV = 1000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  score_display_if.slave  bus
);

  localparam int CW = $clog2(BW + 1);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [BW-1:0] MAX_VAL  = BW'(99);
  localparam logic [CW-1:0] LAST_BIT = CW'(BW - 1);
  localparam logic [RW-1:0] REF_MAX  = RW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t        state_r;
  logic [7:0]    bcd_r;
  logic [BW-1:0] bin_r;
  logic [CW-1:0] bit_cnt_r;
  logic [3:0]    tens_r;
  logic [3:0]    ones_r;
  logic          done_r;
  logic [RW-1:0] ref_cnt_r;
  logic [1:0]    digit_sel_r;
  logic [BW+7:0] shifted_s;
  logic [6:0]    segments_s;

  // Add-3 correction applied to each BCD nibble before a shift.
  function automatic logic [7:0] dd_adjust(input logic [7:0] bcd);
    logic [3:0] hi;
    logic [3:0] lo;
    if (bcd[7:4] >= 4'd5) hi = bcd[7:4] + 4'd3;
    else                  hi = bcd[7:4];
    if (bcd[3:0] >= 4'd5) lo = bcd[3:0] + 4'd3;
    else                  lo = bcd[3:0];
    return {hi, lo};
  endfunction

  // Digit to gfedcba segment pattern; non-BCD codes go dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h00;
    endcase
    return seg;
  endfunction

  // One double-dabble step: correct the BCD nibbles, then shift {bcd, bin} left.
  always_comb begin
    shifted_s = {dd_adjust(bcd_r), bin_r} << 1'b1;
  end

  // Conversion FSM: sample (clamped), shift BW times, publish the digits.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r   <= ST_IDLE;
      bcd_r     <= 8'h00;
      bin_r     <= {BW{1'b0}};
      bit_cnt_r <= {CW{1'b0}};
      tens_r    <= 4'd0;
      ones_r    <= 4'd0;
      done_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          bcd_r     <= 8'h00;
          bin_r     <= (bus.value_i > MAX_VAL) ? MAX_VAL : bus.value_i;
          bit_cnt_r <= {CW{1'b0}};
          state_r   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          bcd_r     <= shifted_s[BW+7:BW];
          bin_r     <= shifted_s[BW-1:0];
          bit_cnt_r <= bit_cnt_r + CW'(1);
          if (bit_cnt_r == LAST_BIT) state_r <= ST_UPDATE;
          else                       state_r <= ST_SHIFT;
        end
        ST_UPDATE: begin
          tens_r  <= bcd_r[7:4];
          ones_r  <= bcd_r[3:0];
          done_r  <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Refresh timer: each digit stays lit REFRESH_DIV cycles, then the select flips.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ref_cnt_r   <= {RW{1'b0}};
      digit_sel_r <= 2'b01;
    end else if (ref_cnt_r == REF_MAX) begin
      ref_cnt_r   <= {RW{1'b0}};
      digit_sel_r <= (digit_sel_r == 2'b01) ? 2'b10 : 2'b01;
    end else begin
      ref_cnt_r   <= ref_cnt_r + RW'(1);
      digit_sel_r <= digit_sel_r;
    end
  end

  // Segment mux: decode whichever digit is currently selected.
  always_comb begin
    segments_s = 7'h00;
    if (digit_sel_r == 2'b10) begin
`ifdef SCORE_BLANK_LEADING_ZERO_EN
      if (tens_r == 4'd0) segments_s = 7'h00;
      else                segments_s = seg_decode(tens_r);
`else
      segments_s = seg_decode(tens_r);
`endif
    end else begin
      segments_s = seg_decode(ones_r);
    end
  end

  assign bus.segments_o  = segments_s;
  assign bus.digit_sel_o = digit_sel_r;
  assign bus.tens_o      = tens_r;
  assign bus.ones_o      = ones_r;
  assign bus.done_o      = done_r;

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: directed, table-driven bench for score_display with a
// short refresh period; also walks reset, sweep, mid-conversion change and
// reset-during-conversion sequences.
module tb_score_display;

  localparam int BW = 7;
  localparam int RD = 20;

  logic clk;
  logic rst_i;
  int   total;
  int   bad;

  score_display_if #(.BW(BW)) bus ();

  score_display #(.BW(BW), .REFRESH_DIV(RD)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int         value;
    int         tens;
    int         ones;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Advance on negedges until done_o is seen; cycles = -1 if the bound expires.
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) begin
        cycles = n;
        break;
      end
    end
  endtask

  // Advance until digit_sel_o equals sel; found = 0 on timeout.
  task automatic wait_sel(input logic [1:0] sel, output int found);
    found = 0;
    for (int n = 0; n < 3 * RD; n++) begin
      if (bus.digit_sel_o == sel) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  function automatic logic [6:0] tens_seg(input int tens, input logic [6:0] seg);
`ifdef SCORE_BLANK_LEADING_ZERO_EN
    if (tens == 0) return 7'h00;
    else           return seg;
`else
    return seg;
`endif
  endfunction

  initial begin
    int c;
    int f;
    int t0;
    logic [1:0] prev;

    total = 0;
    bad   = 0;

    vecs[0]  = '{0,   0, 0, 7'h3F, 7'h3F};
    vecs[1]  = '{42,  4, 2, 7'h66, 7'h5B};
    vecs[2]  = '{99,  9, 9, 7'h6F, 7'h6F};
    vecs[3]  = '{100, 9, 9, 7'h6F, 7'h6F};
    vecs[4]  = '{127, 9, 9, 7'h6F, 7'h6F};
    vecs[5]  = '{7,   0, 7, 7'h3F, 7'h07};
    vecs[6]  = '{70,  7, 0, 7'h07, 7'h3F};
    vecs[7]  = '{9,   0, 9, 7'h3F, 7'h6F};
    vecs[8]  = '{10,  1, 0, 7'h06, 7'h3F};
    vecs[9]  = '{55,  5, 5, 7'h6D, 7'h6D};
    vecs[10] = '{83,  8, 3, 7'h7F, 7'h4F};
    vecs[11] = '{16,  1, 6, 7'h06, 7'h7D};

    // Reset state
    rst_i = 1'b0;
    bus.value_i = 7'd0;
    repeat (3) @(negedge clk);
    check("rst_tens", int'(bus.tens_o), 0);
    check("rst_ones", int'(bus.ones_o), 0);
    check("rst_done", int'(bus.done_o), 0);
    check("rst_sel",  int'(bus.digit_sel_o), 1);
    check("rst_seg",  int'(bus.segments_o), 'h3F);

    // First conversion after release
    rst_i = 1'b1;
    wait_done(c);
    check("first_done_lat", c, 9);
    check("first_tens", int'(bus.tens_o), 0);
    check("first_ones", int'(bus.ones_o), 0);

    // Refresh period: measure two full digit-lit intervals
    prev = bus.digit_sel_o;
    t0 = 0;
    for (int n = 0; n < 3 * RD && t0 == 0; n++) begin
      @(negedge clk);
      if (bus.digit_sel_o != prev) t0 = 1;
      prev = bus.digit_sel_o;
    end
    check("sel_toggle_seen", t0, 1);
    for (int k = 0; k < 2; k++) begin
      c = -1;
      for (int n = 1; n <= 3 * RD; n++) begin
        @(negedge clk);
        check("sel_onehot", int'(bus.digit_sel_o == 2'b01 || bus.digit_sel_o == 2'b10), 1);
        if (bus.digit_sel_o != prev) begin
          c = n;
          prev = bus.digit_sel_o;
          break;
        end
      end
      check("refresh_period", c, RD);
    end

    // Table: each value converted, period checked, both display slots checked
    for (int i = 0; i < 12; i++) begin
      wait_done(c);
      bus.value_i = BW'(vecs[i].value);
      wait_done(c);
      check("conv_period", c, 9);
      check($sformatf("tens_v%0d", vecs[i].value), int'(bus.tens_o), vecs[i].tens);
      check($sformatf("ones_v%0d", vecs[i].value), int'(bus.ones_o), vecs[i].ones);
      wait_sel(2'b01, f);
      check("sel01_seen", f, 1);
      check($sformatf("seg_ones_v%0d", vecs[i].value), int'(bus.segments_o), int'(vecs[i].seg_ones));
      wait_sel(2'b10, f);
      check("sel10_seen", f, 1);
      check($sformatf("seg_tens_v%0d", vecs[i].value), int'(bus.segments_o),
            int'(tens_seg(vecs[i].tens, vecs[i].seg_tens)));
    end

    // Sweep 0..99: each result must reconstruct the sampled value
    wait_done(c);
    for (int v = 0; v < 100; v++) begin
      bus.value_i = BW'(v);
      wait_done(c);
      check($sformatf("sweep_%0d", v), 10 * int'(bus.tens_o) + int'(bus.ones_o), v);
    end

    // Mid-conversion change is ignored until the next sample
    bus.value_i = 7'd42;
    wait_done(c);
    check("mid_sync_lat", c, 9);
    repeat (2) @(negedge clk);
    bus.value_i = 7'd17;
    wait_done(c);
    check("mid_old_tens", int'(bus.tens_o), 4);
    check("mid_old_ones", int'(bus.ones_o), 2);
    wait_done(c);
    check("mid_new_tens", int'(bus.tens_o), 1);
    check("mid_new_ones", int'(bus.ones_o), 7);

    // Reset pulse during SHIFT
    bus.value_i = 7'd55;
    wait_done(c);
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    #1;
    check("mrst_tens", int'(bus.tens_o), 0);
    check("mrst_ones", int'(bus.ones_o), 0);
    check("mrst_done", int'(bus.done_o), 0);
    check("mrst_sel",  int'(bus.digit_sel_o), 1);
    check("mrst_seg",  int'(bus.segments_o), 'h3F);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    wait_done(c);
    check("mrst_done_lat", c, 9);
    check("mrst_new_tens", int'(bus.tens_o), 5);
    check("mrst_new_ones", int'(bus.ones_o), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/score_display.md
# score_display

Display-side consumer of the scoreboard counter value. Takes the binary count (0–99) and converts it to two BCD digits with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes the digits onto one shared 7-segment bus with a one-hot digit select. It sits directly downstream of the counter and drives the board's two-digit display.

## Interface
- BW, 7, width of value_i (must be ≥ 7)
- REFRESH_DIV, 1000, clock cycles each digit stays lit (≥ 2)
- clk_i  input  1  single system clock, rising-edge
- rst_i  input  1  asynchronous, active-low reset
- value_i  input  BW  binary count from the counter
- segments_o  output  7  segment drive, active-high, bit order gfedcba
- digit_sel_o  output  2  one-hot digit enable, active-high; bit0 = ones, bit1 = tens
- tens_o  output  4  registered BCD tens digit
- ones_o  output  4  registered BCD ones digit
- done_o  output  1  one-cycle pulse: new tens_o/ones_o valid

## Operation
Conversion FSM states:
- IDLE: one cycle. Samples value_i into the shift register, clamped: any value > 99 loads as 99. Next state is SHIFT; the bit counter is cleared.
- SHIFT: BW cycles. Each cycle:
  - add 3 to any BCD nibble ≥ 5;
  - then shift {bcd, bin} left by one;
  - increment the bit counter.
  - Leaves SHIFT after the BW-th shift.
- UPDATE: one cycle. Writes tens_o/ones_o from the BCD register, then returns to IDLE.
- Conversion runs continuously. There is no start handshake: every BW+2 cycles, value_i is resampled.
- The BCD working register is 8 bits (two nibbles). The hundreds nibble is not needed because of the clamp.

Refresh:
- ref_cnt counts 0..REFRESH_DIV-1 and wraps to 0.
- On the wrap edge, digit_sel_o toggles between 2'b01 and 2'b10.

Segment decode:
- segments_o is combinational from the registered digit_sel_o and tens_o/ones_o.
- Digit codes 0–9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex).
- Any non-BCD nibble decodes to 00 (unreachable; defensive).

## Timing
- Reset values (asynchronous assert, while rst_i low):
  - FSM = IDLE; shift and bit counters = 0
  - tens_o = 0, ones_o = 0, done_o = 0
  - ref_cnt = 0, digit_sel_o = 2'b01
  - segments_o = 7'h3F
- value_i is sampled on the clock edge leaving IDLE, edge k.
- SHIFT occupies edges k+1 .. k+BW.
- tens_o/ones_o update on edge k+BW+1. done_o is high for exactly the cycle after that edge.
- Latency from sample to valid digits is BW+1 edges. done_o period is BW+2 cycles (9 for BW=7).
- value_i changes mid-conversion are ignored until the next IDLE sample.
- The display never shows a partial conversion: tens_o/ones_o change only in UPDATE.
- Each digit is lit for exactly REFRESH_DIV cycles.
- digit_sel_o is never 2'b00 or 2'b11 out of reset.
- If UPDATE and a refresh wrap fall on the same edge, both take effect. segments_o then shows the new digit's new value in the next cycle.
- Reset asserted mid-conversion:
  - aborts immediately to the reset values;
  - conversion restarts from IDLE on the first edge after release;
  - the first done_o comes BW+2 cycles after release.

## Configuration
- `SCORE_BLANK_LEADING_ZERO_EN` defined:
  - when tens_o == 0 and digit_sel_o == 2'b10, segments_o = 7'h00 (values 0–9 show a single digit);
  - ones digit always displayed, including 0.
- Not defined: the tens digit always shows, e.g. "07" for value 7.
- tens_o/ones_o/done_o are identical in both builds.

## Test plan
- Reset then hold: release rst_i with value_i = 0.
  - All outputs at reset values; segments_o = 3F.
  - First done_o 9 cycles after release, with tens/ones = 0/0.
- Value 42: hold value_i = 42.
  - Next done_o gives tens_o = 4, ones_o = 2.
  - With digit_sel_o = 01, segments_o = 5B. After REFRESH_DIV cycles, digit_sel_o = 10 and segments_o = 66.
- Boundaries: value_i = 99 → 9/9 (6F/6F); value_i = 0 → 0/0; value_i = 100 and 127 → clamped to 9/9.
- Sweep: ramp value_i 0→99, held one full conversion period each. Every done_o must satisfy 10·tens_o + ones_o == sampled value.
- Mid-conversion change: change 42→17 two cycles after sampling.
  - The current done_o still reports 4/2; the following one reports 1/7.
- Reset mid-conversion: pulse rst_i low during SHIFT.
  - Outputs return to reset values immediately.
  - No done_o until BW+2 cycles after release.
- With `SCORE_BLANK_LEADING_ZERO_EN`: value 7 gives tens slot segments_o = 00 and ones slot 07. Value 70 gives 07 and 3F.
